// File: rtl/io_ring_pkg.sv
// Shared types for the IO ring power sequencer.
// State encoding, pad control bundle and its safe value.
package io_ring_pkg;

    typedef enum logic [3:0] {
        OFF,
        DEBOUNCE,
        ISO_REL,
        IE_EN,
        OE_EN,
        ACTIVE,
        SLP_ENT,
        SLEEP,
        WAKE
    } ring_state_e;

    typedef struct packed {
        logic ret;
        logic iso;
        logic ie;
        logic oe;
    } pad_ctrl_t;

    localparam pad_ctrl_t PAD_SAFE = '{
        ret: 1'b0,
        iso: 1'b1,
        ie:  1'b0,
        oe:  1'b0
    };

    // WAKE folds onto 3'b111; sleeping_o tells it apart from SLEEP
    function automatic logic [2:0] state_code(ring_state_e s);
        logic [3:0] raw;
        raw = s;
        return raw[3] ? 3'b111 : raw[2:0];
    endfunction

endpackage

// File: rtl/io_ring_sync.sv
// Multi-flop synchroniser for one asynchronous supply flag.
// Chain clears to 0 so a fresh reset reads as supply-not-good.
module io_ring_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flag,
    output logic flag_sync
);

    logic [STAGES-1:0] chain;

    // shift the async flag through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], flag};
        end
    end

    assign flag_sync = chain[STAGES-1];

endmodule

// File: rtl/io_ring_pwr_seq.sv
// IO ring supply sequencer: debounce, staged pad enables, sleep/wake.
// Supply loss after debounce drops the ring to the safe state and latches a fault.
module io_ring_pwr_seq
    import io_ring_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 1024,
    parameter int STEP_CYCLES = 16,
    parameter int CNT_W       = 11
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       vddio_ok_i,
    input  logic       vdd_ok_i,
    input  logic       sleep_req_i,
    output logic       pad_ret_o,
    output logic       pad_iso_o,
    output logic       pad_ie_o,
    output logic       pad_oe_o,
    output logic       ring_ready_o,
    output logic       sleeping_o,
    output logic [2:0] state_o,
    output logic       fault_o
);

    logic             vddio_sync;
    logic             vdd_sync;
    logic             supply_ok;
    ring_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             step_done;
    logic             deb_done;
    pad_ctrl_t        pad;
    logic             ready;
    logic             sleeping;
    logic             fault;

    io_ring_sync #(.STAGES(SYNC_STAGES)) u_sync_vddio (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flag      (vddio_ok_i),
        .flag_sync (vddio_sync)
    );

    io_ring_sync #(.STAGES(SYNC_STAGES)) u_sync_vdd (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flag      (vdd_ok_i),
        .flag_sync (vdd_sync)
    );

    assign supply_ok = vddio_sync & vdd_sync;
    assign cnt_inc   = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign step_done = (cnt == CNT_W'(STEP_CYCLES - 1));
    assign deb_done  = (cnt == CNT_W'(DEB_CYCLES - 1));

    // sequencer FSM with shared counter and registered pad controls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= OFF;
            cnt      <= '0;
            pad      <= PAD_SAFE;
            ready    <= 1'b0;
            sleeping <= 1'b0;
            fault    <= 1'b0;
        end else if (!supply_ok && state != OFF && state != DEBOUNCE) begin
            state    <= OFF;
            cnt      <= '0;
            pad      <= PAD_SAFE;
            ready    <= 1'b0;
            sleeping <= 1'b0;
            fault    <= 1'b1;
        end else begin
            cnt <= cnt_inc;
            case (state)
                OFF: begin
                    cnt <= '0;
                    if (supply_ok) begin
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!supply_ok) begin
                        cnt <= '0;
                    end else if (deb_done) begin
                        state   <= ISO_REL;
                        cnt     <= '0;
                        pad.iso <= 1'b0;
                    end
                end
                ISO_REL: begin
                    if (step_done) begin
                        state  <= IE_EN;
                        cnt    <= '0;
                        pad.ie <= 1'b1;
                    end
                end
                IE_EN: begin
                    if (step_done) begin
                        state  <= OE_EN;
                        cnt    <= '0;
                        pad.oe <= 1'b1;
                    end
                end
                OE_EN: begin
                    if (step_done) begin
                        state <= ACTIVE;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end
                end
                ACTIVE: begin
                    cnt <= '0;
                    if (sleep_req_i) begin
                        state   <= SLP_ENT;
                        pad.ret <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                SLP_ENT: begin
                    if (step_done) begin
                        state    <= SLEEP;
                        cnt      <= '0;
                        pad.iso  <= 1'b1;
                        pad.oe   <= 1'b0;
                        pad.ie   <= 1'b0;
                        sleeping <= 1'b1;
                    end
                end
                SLEEP: begin
                    cnt <= '0;
                    if (!sleep_req_i) begin
                        state    <= WAKE;
                        sleeping <= 1'b0;
                        pad.ie   <= 1'b1;
                        pad.oe   <= 1'b1;
                    end
                end
                WAKE: begin
                    if (step_done) begin
                        state   <= ACTIVE;
                        cnt     <= '0;
                        pad.iso <= 1'b0;
                        pad.ret <= 1'b0;
                        ready   <= 1'b1;
                    end
                end
                default: begin
                    state    <= OFF;
                    cnt      <= '0;
                    pad      <= PAD_SAFE;
                    ready    <= 1'b0;
                    sleeping <= 1'b0;
                end
            endcase
        end
    end

    assign pad_ret_o    = pad.ret;
    assign pad_iso_o    = pad.iso;
    assign pad_ie_o     = pad.ie;
    assign pad_oe_o     = pad.oe;
    assign ring_ready_o = ready;
    assign sleeping_o   = sleeping;
    assign fault_o      = fault;
    assign state_o      = state_code(state);

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Bench for io_ring_pwr_seq: directed timing scenarios plus random stimulus
// against a phase/dwell-time model of the sequencer.
module tb_io_ring_pwr_seq;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int STEP = 4;

    localparam int P_OFF = 0;
    localparam int P_DEB = 1;
    localparam int P_ISO = 2;
    localparam int P_IE  = 3;
    localparam int P_OE  = 4;
    localparam int P_ACT = 5;
    localparam int P_SLE = 6;
    localparam int P_SLP = 7;
    localparam int P_WAK = 8;

    logic       clk;
    logic       rst_n;
    logic       vddio_ok;
    logic       vdd_ok;
    logic       sleep_req;
    logic       pad_ret;
    logic       pad_iso;
    logic       pad_ie;
    logic       pad_oe;
    logic       ring_ready;
    logic       sleeping;
    logic [2:0] state;
    logic       fault;

    int total = 0;
    int bad   = 0;

    int ph;
    int dwell;
    bit mfault;
    bit hist[$];

    int iso_at;
    int ie_at;
    int oe_at;
    int rdy_at;
    int st2;
    int st3;

    io_ring_pwr_seq #(
        .SYNC_STAGES (SYNC),
        .DEB_CYCLES  (DEB),
        .STEP_CYCLES (STEP),
        .CNT_W       (11)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .vddio_ok_i   (vddio_ok),
        .vdd_ok_i     (vdd_ok),
        .sleep_req_i  (sleep_req),
        .pad_ret_o    (pad_ret),
        .pad_iso_o    (pad_iso),
        .pad_ie_o     (pad_ie),
        .pad_oe_o     (pad_oe),
        .ring_ready_o (ring_ready),
        .sleeping_o   (sleeping),
        .state_o      (state),
        .fault_o      (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // {ret,iso,ie,oe,ready,sleeping} expected while dwelling in a phase
    function automatic logic [5:0] exp_pads(int p);
        case (p)
            P_ISO:   return 6'b000000;
            P_IE:    return 6'b001000;
            P_OE:    return 6'b001100;
            P_ACT:   return 6'b001110;
            P_SLE:   return 6'b101100;
            P_SLP:   return 6'b110001;
            P_WAK:   return 6'b111100;
            default: return 6'b010000;
        endcase
    endfunction

    function automatic int after(int p);
        case (p)
            P_ISO:   return P_IE;
            P_IE:    return P_OE;
            P_OE:    return P_ACT;
            P_SLE:   return P_SLP;
            default: return P_ACT;
        endcase
    endfunction

    function automatic logic [31:0] dut_outs();
        return {25'd0, pad_ret, pad_iso, pad_ie, pad_oe,
                ring_ready, sleeping, fault};
    endfunction

    task automatic model_reset();
        ph     = P_OFF;
        dwell  = 0;
        mfault = 1'b0;
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    endtask

    // one clock edge of the reference: supply is seen SYNC edges late
    task automatic model_step();
        bit sup;
        sup = hist.pop_front();
        hist.push_back(vddio_ok & vdd_ok);
        if (ph >= P_ISO && !sup) begin
            ph     = P_OFF;
            dwell  = 0;
            mfault = 1'b1;
        end else begin
            case (ph)
                P_OFF: begin
                    if (sup) begin
                        ph    = P_DEB;
                        dwell = 0;
                    end
                end
                P_DEB: begin
                    if (!sup) dwell = 0;
                    else if (dwell == DEB - 1) begin
                        ph    = P_ISO;
                        dwell = 0;
                    end else dwell++;
                end
                P_ACT: begin
                    if (sleep_req) begin
                        ph    = P_SLE;
                        dwell = 0;
                    end
                end
                P_SLP: begin
                    if (!sleep_req) begin
                        ph    = P_WAK;
                        dwell = 0;
                    end
                end
                default: begin
                    if (dwell == STEP - 1) begin
                        ph    = after(ph);
                        dwell = 0;
                    end else dwell++;
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("outs", dut_outs(), {25'd0, exp_pads(ph), mfault});
        if (ph == P_OFF) chk("st_off", 32'(state), 0);
        if (ph == P_DEB) chk("st_deb", 32'(state), 1);
        if (ph == P_ACT) chk("st_act", 32'(state), 5);
    endtask

    // called at a falling edge; pulses reset between clock edges
    task automatic do_async_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_outs", dut_outs(), 32'h20);
        chk("rst_state", 32'(state), 0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    task automatic run_track(input int n, input int glitch_at);
        iso_at = 0;
        ie_at  = 0;
        oe_at  = 0;
        rdy_at = 0;
        for (int k = 1; k <= n; k++) begin
            if (k == glitch_at) vdd_ok = 1'b0;
            if (k == glitch_at + 1) vdd_ok = 1'b1;
            tick();
            if (k == 2) st2 = int'(state);
            if (k == 3) st3 = int'(state);
            if (iso_at == 0 && !pad_iso) iso_at = k;
            if (ie_at == 0 && pad_ie) ie_at = k;
            if (oe_at == 0 && pad_oe) oe_at = k;
            if (rdy_at == 0 && ring_ready) rdy_at = k;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        vddio_ok  = 1'b0;
        vdd_ok    = 1'b0;
        sleep_req = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("por_outs", dut_outs(), 32'h20);
        chk("por_state", 32'(state), 0);
        rst_n = 1'b1;

        // power-up timing
        vddio_ok = 1'b1;
        vdd_ok   = 1'b1;
        run_track(30, 0);
        chk("pu_st2", 32'(st2), 0);
        chk("pu_st3", 32'(st3), 1);
        chk("pu_iso", 32'(iso_at), 11);
        chk("pu_ie", 32'(ie_at), 15);
        chk("pu_oe", 32'(oe_at), 19);
        chk("pu_rdy", 32'(rdy_at), 23);

        // sleep entry and wake
        sleep_req = 1'b1;
        tick();
        chk("slp_ret", 32'(pad_ret), 1);
        chk("slp_rdy", 32'(ring_ready), 0);
        repeat (3) tick();
        chk("slp_iso_hold", 32'(pad_iso), 0);
        tick();
        chk("slp_safe", 32'({pad_iso, pad_ie, pad_oe, sleeping}), 32'h9);
        repeat (3) tick();
        sleep_req = 1'b0;
        tick();
        chk("wk_drv", 32'({pad_ie, pad_oe, pad_ret, pad_iso, sleeping}), 32'h1e);
        repeat (3) tick();
        chk("wk_ret_hold", 32'(pad_ret), 1);
        tick();
        chk("wk_done", 32'({pad_ret, pad_iso, ring_ready}), 32'h1);

        // supply drop coinciding with sleep request
        vdd_ok = 1'b0;
        tick();
        tick();
        sleep_req = 1'b1;
        tick();
        chk("sim_off", dut_outs(), 32'h21);
        chk("sim_state", 32'(state), 0);
        sleep_req = 1'b0;
        repeat (4) tick();

        // supply drop in OE_EN, fault stickiness, drop in SLEEP
        vdd_ok = 1'b1;
        do_async_reset();
        chk("fault_clr", 32'(fault), 0);
        run_track(19, 0);
        vddio_ok = 1'b0;
        tick();
        tick();
        chk("drop_oe_pre", 32'(pad_oe), 1);
        tick();
        chk("drop_oe_safe", dut_outs(), 32'h21);
        vddio_ok = 1'b1;
        run_track(25, 0);
        chk("repwr_rdy", 32'(rdy_at), 23);
        chk("fault_sticky", 32'(fault), 1);
        sleep_req = 1'b1;
        repeat (5) tick();
        chk("slp_in", 32'(sleeping), 1);
        vdd_ok = 1'b0;
        repeat (3) tick();
        chk("drop_slp_safe", dut_outs(), 32'h21);
        sleep_req = 1'b0;
        vdd_ok    = 1'b1;

        // debounce glitch restarts the count
        do_async_reset();
        run_track(40, 9);
        chk("gl_iso", 32'(iso_at), 19);
        chk("gl_rdy", 32'(rdy_at), 31);

        // async reset in the middle of WAKE
        sleep_req = 1'b1;
        repeat (6) tick();
        sleep_req = 1'b0;
        repeat (2) tick();
        chk("mid_wake_ret", 32'(pad_ret), 1);
        do_async_reset();
        run_track(25, 0);
        chk("reseq_rdy", 32'(rdy_at), 23);

        // random stimulus against the reference model
        for (int c = 0; c < 4000; c++) begin
            if (!vddio_ok) begin
                if ($urandom_range(3) == 0) vddio_ok = 1'b1;
            end else if ($urandom_range(199) == 0) vddio_ok = 1'b0;
            if (!vdd_ok) begin
                if ($urandom_range(3) == 0) vdd_ok = 1'b1;
            end else if ($urandom_range(199) == 0) vdd_ok = 1'b0;
            if ($urandom_range(39) == 0) sleep_req = ~sleep_req;
            if ($urandom_range(1999) == 0) do_async_reset();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
